// File: rtl/hilo_ctrl_if.sv
// Divider handshake bundle between hilo_ctrl (master) and the iterative radix-2 divider (slave).
interface hilo_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 div_opn_valid;
  logic                 div_sign;
  logic [WIDTH-1:0]     div_a;
  logic [WIDTH-1:0]     div_b;
  logic                 div_res_ready;
  logic                 div_res_valid;
  logic [2*WIDTH-1:0]   div_result;
  logic                 div_cancel;

  modport master (
    output div_opn_valid, div_sign, div_a, div_b, div_res_ready, div_cancel,
    input  div_res_valid, div_result
  );

  modport slave (
    input  div_opn_valid, div_sign, div_a, div_b, div_res_ready, div_cancel,
    output div_res_valid, div_result
  );
endinterface

// File: rtl/hilo_ctrl.sv
// HI/LO register pair and EX-stage multiply/divide sequencer.
// Launches and cancels the iterative divider and commits each HI/LO writer exactly once.
module hilo_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  input  logic               flush,
  input  logic               exc,
  input  logic               stall_m,
  input  logic [2*WIDTH-1:0] mul_result,
  output logic               mul_sign,
  hilo_ctrl_if.master        div,
  output logic               stall_e,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [5:0]         div_cnt
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [5:0] CNT_MAX  = 6'd63;

  typedef enum logic [1:0] {
    IDLE,
    DIV_BUSY,
    DIV_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   hi_nxt, lo_nxt;
  logic [WIDTH-1:0]   a_nxt, b_nxt;
  logic               sign_nxt;
  logic [5:0]         cnt_nxt;
  logic               fire;
  logic               is_div;

  assign fire   = op_valid & ~stall_m & ~exc & ~flush;
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);

  // State and architectural registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hi           <= '0;
      lo           <= '0;
      div.div_a    <= '0;
      div.div_b    <= '0;
      div.div_sign <= 1'b0;
      div_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      hi           <= hi_nxt;
      lo           <= lo_nxt;
      div.div_a    <= a_nxt;
      div.div_b    <= b_nxt;
      div.div_sign <= sign_nxt;
      div_cnt      <= cnt_nxt;
    end
  end

  // Next-state, commit selection and handshake outputs
  always_comb begin
    state_nxt         = state;
    hi_nxt            = hi;
    lo_nxt            = lo;
    a_nxt             = div.div_a;
    b_nxt             = div.div_b;
    sign_nxt          = div.div_sign;
    cnt_nxt           = div_cnt;
    stall_e           = 1'b0;
    div.div_opn_valid = 1'b0;
    div.div_res_ready = 1'b0;
    div.div_cancel    = rst;
    mul_sign          = (op == OP_MULT);

    case (state)
      IDLE: begin
        // Divide launch ignores stall_m: the divider can start while MEM is held
        if (op_valid && is_div && !exc && !flush) begin
          state_nxt = DIV_BUSY;
          a_nxt     = rs_val;
          b_nxt     = rt_val;
          sign_nxt  = (op == OP_DIV);
          cnt_nxt   = '0;
          stall_e   = 1'b1;
        end else if (fire) begin
          case (op)
            OP_MULT, OP_MULTU: {hi_nxt, lo_nxt} = mul_result;
            OP_MTHI:           hi_nxt = rs_val;
            OP_MTLO:           lo_nxt = rs_val;
            default:           ;
          endcase
        end
      end

      DIV_BUSY: begin
        div.div_opn_valid = 1'b1;
        stall_e           = 1'b1;
        cnt_nxt           = (div_cnt == CNT_MAX) ? div_cnt : div_cnt + 6'd1;
        if (flush || exc) begin
          div.div_cancel = 1'b1;
          state_nxt      = IDLE;
        end else if (div.div_res_valid && !stall_m) begin
          div.div_res_ready = 1'b1;
          hi_nxt            = div.div_result[2*WIDTH-1:WIDTH];
          lo_nxt            = div.div_result[WIDTH-1:0];
          state_nxt         = DIV_DONE;
        end
      end

      // Divide is retiring from EX; its op is still visible but must not relaunch
      DIV_DONE: begin
        if (!stall_m) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      stall_e           = 1'b0;
      div.div_opn_valid = 1'b0;
      div.div_res_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl with a latency-34 divider model and an HI/LO scoreboard.
module tb_hilo_ctrl;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 34;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic           clk;
  logic           rst;
  logic           op_valid;
  logic [2:0]     op;
  logic [W-1:0]   rs_val;
  logic [W-1:0]   rt_val;
  logic           flush;
  logic           exc;
  logic           stall_m;
  logic [2*W-1:0] mul_result;
  logic           mul_sign;
  logic           stall_e;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic [5:0]     div_cnt;
  logic [7:0]     mcnt;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  hilo_ctrl_if #(.WIDTH(W)) dif ();

  hilo_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op         (op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .flush      (flush),
    .exc        (exc),
    .stall_m    (stall_m),
    .mul_result (mul_result),
    .mul_sign   (mul_sign),
    .div        (dif.master),
    .stall_e    (stall_e),
    .hi         (hi),
    .lo         (lo),
    .div_cnt    (div_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational multiplier model
  always_comb begin
    if (op == 3'b001)
      mul_result = $signed({{W{rs_val[W-1]}}, rs_val}) * $signed({{W{rt_val[W-1]}}, rt_val});
    else
      mul_result = {{W{1'b0}}, rs_val} * {{W{1'b0}}, rt_val};
  end

  // Divider model: result valid on the LAT-th cycle after launch, held until accepted
  always_ff @(posedge clk) begin
    if (dif.div_cancel || !dif.div_opn_valid) mcnt <= '0;
    else if (!(dif.div_res_valid && dif.div_res_ready)) mcnt <= mcnt + 8'd1;
  end

  assign dif.div_res_valid = dif.div_opn_valid && (mcnt >= 8'(LAT - 1));

  always_comb begin
    dif.div_result = '0;
    if (dif.div_b != '0) begin
      if (dif.div_sign)
        dif.div_result = {W'($signed(dif.div_a) % $signed(dif.div_b)),
                          W'($signed(dif.div_a) / $signed(dif.div_b))};
      else
        dif.div_result = {dif.div_a % dif.div_b, dif.div_a / dif.div_b};
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] h, input logic [W-1:0] l);
    exp_t e;
    e.hi = h;
    e.lo = l;
    sb.push_back(e);
  endtask

  task automatic chk_hilo(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
      chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
    end
  endtask

  // Counts remaining stall_e cycles, bounded; stops in the first non-stalled cycle
  task automatic run_div(output int n);
    n = 0;
    while (stall_e === 1'b1 && n < 200) begin
      n++;
      cyc();
      #2;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; op_valid = 1'b0; op = 3'b000; rs_val = '0; rt_val = '0;
    flush = 1'b0; exc = 1'b0; stall_m = 1'b0;

    cyc(); cyc(); #2;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_cnt", 64'(div_cnt), 64'd0);
    chk("rst_cancel", 64'(dif.div_cancel), 64'd1);
    chk("rst_stall_e", 64'(stall_e), 64'd0);
    chk("rst_opn_valid", 64'(dif.div_opn_valid), 64'd0);
    chk("rst_res_ready", 64'(dif.div_res_ready), 64'd0);
    cyc(); rst = 1'b0; #2;
    chk("cancel_after_rst", 64'(dif.div_cancel), 64'd0);

    // MULT / MULTU
    cyc(); op_valid = 1'b1; op = 3'b001; rs_val = 32'hFFFF_FFFE; rt_val = 32'd3; #2;
    chk("mul_sign_mult", 64'(mul_sign), 64'd1);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFA);
    cyc(); op = 3'b010; #2;
    chk_hilo("mult");
    chk("mul_sign_multu", 64'(mul_sign), 64'd0);
    push(32'h0000_0002, 32'hFFFF_FFFA);
    cyc(); op_valid = 1'b0; op = 3'b000; #2;
    chk_hilo("multu");

    // MULT held by stall_m does not fire
    cyc(); op_valid = 1'b1; op = 3'b001; rs_val = 32'd5; rt_val = 32'd7; stall_m = 1'b1;
    push(32'h0000_0002, 32'hFFFF_FFFA);
    cyc(); op_valid = 1'b0; stall_m = 1'b0; #2;
    chk_hilo("mult_stall_m");

    // MTHI with exc, then without; MTLO; reserved op
    cyc(); op_valid = 1'b1; op = 3'b101; rs_val = 32'h1234_5678; exc = 1'b1;
    push(32'h0000_0002, 32'hFFFF_FFFA);
    cyc(); exc = 1'b0; #2;
    chk_hilo("mthi_exc");
    push(32'h1234_5678, 32'hFFFF_FFFA);
    cyc(); op = 3'b110; rs_val = 32'hCAFE_F00D; #2;
    chk_hilo("mthi");
    push(32'h1234_5678, 32'hCAFE_F00D);
    cyc(); op = 3'b111; rs_val = 32'hDEAD_BEEF; #2;
    chk_hilo("mtlo");
    push(32'h1234_5678, 32'hCAFE_F00D);
    cyc(); op_valid = 1'b0; op = 3'b000; #2;
    chk_hilo("reserved");

    // DIV 100/7, full latency
    cyc(); op_valid = 1'b1; op = 3'b011; rs_val = 32'd100; rt_val = 32'd7; #2;
    push(32'd2, 32'd14);
    chk("div_launch_stall", 64'(stall_e), 64'd1);
    chk("div_launch_opn", 64'(dif.div_opn_valid), 64'd0);
    cyc(); #2;
    chk("div_a", 64'(dif.div_a), 64'd100);
    chk("div_b", 64'(dif.div_b), 64'd7);
    chk("div_sign", 64'(dif.div_sign), 64'd1);
    chk("div_busy_opn", 64'(dif.div_opn_valid), 64'd1);
    run_div(n);
    chk("div_stall_cycles", 64'(n + 1), 64'd35);
    chk_hilo("div");
    chk("div_cnt", 64'(div_cnt), 64'd34);
    chk("div_done_opn", 64'(dif.div_opn_valid), 64'd0);
    chk("div_done_stall", 64'(stall_e), 64'd0);
    cyc(); op_valid = 1'b0; #2;
    chk("div_idle_opn", 64'(dif.div_opn_valid), 64'd0);
    chk("div_idle_stall", 64'(stall_e), 64'd0);

    // DIV cancelled by exc ten cycles in
    cyc(); op_valid = 1'b1; op = 3'b011; rs_val = 32'd50; rt_val = 32'd5;
    push(32'd2, 32'd14);
    repeat (10) cyc();
    exc = 1'b1; #2;
    chk("exc_cancel", 64'(dif.div_cancel), 64'd1);
    chk("exc_stall", 64'(stall_e), 64'd1);
    chk("exc_res_ready", 64'(dif.div_res_ready), 64'd0);
    cyc(); exc = 1'b0; op_valid = 1'b0; #2;
    chk("exc_cancel_drop", 64'(dif.div_cancel), 64'd0);
    chk("exc_stall_drop", 64'(stall_e), 64'd0);
    chk("exc_cnt", 64'(div_cnt), 64'd10);
    chk_hilo("div_exc");

    // Signed DIV with result held off by stall_m for 3 cycles
    cyc(); op_valid = 1'b1; op = 3'b011; rs_val = 32'hFFFF_FF9C; rt_val = 32'd7;
    push(32'hFFFF_FFFE, 32'hFFFF_FFF2);
    repeat (33) cyc();
    #2;
    chk("res_not_yet", 64'(dif.div_res_valid), 64'd0);
    cyc(); stall_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("held_res_valid", 64'(dif.div_res_valid), 64'd1);
      chk("held_res_ready", 64'(dif.div_res_ready), 64'd0);
      chk("held_stall_e", 64'(stall_e), 64'd1);
      cyc();
    end
    stall_m = 1'b0; #2;
    chk("release_res_ready", 64'(dif.div_res_ready), 64'd1);
    chk("release_hi_old", 64'(hi), 64'd2);
    cyc(); stall_m = 1'b1; flush = 1'b1; #2;
    chk_hilo("div_stall_m");
    chk("stall_m_cnt", 64'(div_cnt), 64'd37);
    chk("done_stall_e", 64'(stall_e), 64'd0);
    chk("done_flush_cancel", 64'(dif.div_cancel), 64'd0);
    cyc(); flush = 1'b0; #2;
    chk("done_hold_opn", 64'(dif.div_opn_valid), 64'd0);
    chk("done_hold_stall", 64'(stall_e), 64'd0);
    cyc(); stall_m = 1'b0; #2;
    chk("done_exit_opn", 64'(dif.div_opn_valid), 64'd0);
    push(32'hFFFF_FFFE, 32'hFFFF_FFF2);
    cyc(); op_valid = 1'b0; #2;
    chk_hilo("done_flush_kept");

    // Reset in the middle of a DIVU
    cyc(); op_valid = 1'b1; op = 3'b100; rs_val = 32'hFFFF_FFF0; rt_val = 32'h10;
    repeat (5) cyc();
    rst = 1'b1; #2;
    chk("mid_rst_cancel", 64'(dif.div_cancel), 64'd1);
    chk("mid_rst_stall", 64'(stall_e), 64'd0);
    chk("mid_rst_opn", 64'(dif.div_opn_valid), 64'd0);
    cyc(); rst = 1'b0; op_valid = 1'b0; #2;
    push(32'd0, 32'd0);
    chk_hilo("mid_rst");
    chk("mid_rst_stall_after", 64'(stall_e), 64'd0);
    chk("mid_rst_cancel_after", 64'(dif.div_cancel), 64'd0);
    chk("mid_rst_cnt", 64'(div_cnt), 64'd0);
    chk("mid_rst_div_a", 64'(dif.div_a), 64'd0);

    // DIVU after reset, then a back-to-back DIV
    cyc(); op_valid = 1'b1; op = 3'b100; rs_val = 32'hFFFF_FFF0; rt_val = 32'h10; #2;
    push(32'd0, 32'h0FFF_FFFF);
    chk("divu_launch", 64'(stall_e), 64'd1);
    cyc(); #2;
    chk("divu_sign", 64'(dif.div_sign), 64'd0);
    chk("divu_a", 64'(dif.div_a), 64'hFFFF_FFF0);
    run_div(n);
    chk("divu_stall_cycles", 64'(n + 1), 64'd35);
    chk_hilo("divu");
    cyc(); op = 3'b011; rs_val = 32'd9; rt_val = 32'd2; #2;
    push(32'd1, 32'd4);
    chk("b2b_launch", 64'(stall_e), 64'd1);
    cyc(); #2;
    run_div(n);
    chk("b2b_stall_cycles", 64'(n + 1), 64'd35);
    chk_hilo("div_b2b");
    cyc(); op_valid = 1'b0; op = 3'b000; #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Owns the HI/LO architectural register pair and sequences the EX-stage multiply/divide resource. It launches the iterative radix-2 divider through its valid/ready handshake, stalls EX while a divide runs, and cancels it on flush or exception. It commits MULT/MULTU/DIV/DIVU/MTHI/MTLO results to HI/LO exactly once per instruction. It sits beside the ALU in EX and drives the divider's control and operand inputs.

## Interface
Parameters:
- WIDTH, 32, data width; HI/LO each WIDTH, products/quotient pairs 2*WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset rst, synchronous, active-high
- op_valid  in  1  EX holds a valid instruction
- op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none)
- rs_val  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
- rt_val  in  WIDTH  rt operand (divisor / multiplier)
- flush  in  1  EX flush
- exc  in  1  exception taken this cycle; suppresses all commits
- stall_m  in  1  EX→MEM register held
- mul_result  in  2*WIDTH  combinational product of rs_val, rt_val
- mul_sign  out  1  1 for MULT
- div_opn_valid  out  1  operands valid to divider
- div_sign  out  1  latched, 1 for DIV
- div_a, div_b  out  WIDTH  latched dividend / divisor
- div_res_ready  out  1  result accepted this cycle
- div_res_valid  in  1  divider result valid
- div_result  in  2*WIDTH  {remainder, quotient}
- div_cancel  out  1  abort/reset divider
- stall_e  out  1  hold IF/ID/EX
- hi, lo  out  WIDTH  registered HI/LO
- div_cnt  out  6  cycles spent in current/last divide, saturating at 63

## Operation
- fire = op_valid & ~stall_m & ~exc & ~flush.
- States: IDLE, DIV_BUSY, DIV_DONE.
- IDLE:
  - fire & MULT/MULTU: {hi,lo} <= mul_result.
  - fire & MTHI: hi <= rs_val. fire & MTLO: lo <= rs_val.
  - op_valid & DIV/DIVU & ~exc & ~flush: latch div_a=rs_val, div_b=rt_val, div_sign; div_cnt <= 0; go DIV_BUSY. stall_e=1 combinationally in this cycle. Launch does not depend on stall_m.
- DIV_BUSY:
  - div_opn_valid=1, stall_e=1, div_cnt increments (saturating).
  - flush | exc: div_cancel=1 this cycle, no HILO write, go IDLE. This has priority over a simultaneous div_res_valid.
  - div_res_valid & ~stall_m: div_res_ready=1; hi <= div_result[2W-1:W] (remainder), lo <= div_result[W-1:0] (quotient); go DIV_DONE.
  - div_res_valid & stall_m: stay, div_res_ready=0.
- DIV_DONE:
  - stall_e=0 so the divide leaves EX. No launch and no commit even though op_valid/op still show the divide.
  - Stay while stall_m=1; go IDLE when stall_m=0.
- div_cancel = rst | (DIV_BUSY & (flush|exc)).
- mul_sign derives from current op. Multiply is single-cycle here and has no state.
- Reserved op (111): no effect.

## Timing
- Reset: state IDLE, hi=lo=0, div_a=div_b=0, div_sign=0, div_cnt=0. All handshake outputs are 0 except div_cancel=1 while rst is high.
- Reset mid-divide: next cycle IDLE, no HILO write, stall_e=0.
- MULT/MTHI/MTLO: HI/LO visible on outputs the cycle after fire. No internal bypass; hazard logic must delay a dependent MFHI/MFLO by one cycle.
- DIV, divider valid at cycle N after the launch cycle L:
  - stall_e is high for cycles L..N.
  - HI/LO update at the end of cycle N.
  - DIV_DONE is cycle N+1, with stall_e=0.
  - IDLE is cycle N+2.
- Back-to-back DIVs: the second launches in the cycle after DIV_DONE.
- exc concurrent with a MULT/MTHI/MTLO fire: no write.
- flush/exc in DIV_DONE: the commit has already happened and is not reverted.

## Test plan
- MULT rs=0xFFFFFFFE, rt=3 → next cycle hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU, same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=100, rt=7 with a divider model (res_valid 34 cycles after launch) → stall_e high 35 cycles, then lo=14, hi=2. DIV_DONE has stall_e=0. No relaunch (div_opn_valid stays 0). div_cnt=34.
- DIV then exc 10 cycles in → div_cancel pulses 1 cycle, hi/lo unchanged, stall_e low next cycle.
- Divider result valid while stall_m=1 for 3 cycles → div_res_ready stays 0 those 3 cycles. HI/LO written on the first cycle with stall_m=0.
- MTHI 0x12345678 with exc=1 in the same cycle → hi unchanged. Repeat with exc=0 → hi=0x12345678, lo untouched.
- Assert rst during DIV_BUSY → IDLE, hi=lo=0, div_cancel=1 while rst is high. A DIVU issued afterwards completes normally.
